glyph_blitter: RTL
==================

Name: glyph_blitter

Overview:
- Sequential successor to the per-character combinational LUT decoders.
- Takes one draw request: glyph code, origin, colours, mode, scale.
- Walks the glyph bitmap row by row, using an external glyph ROM port, and emits one pixel write per cycle over a valid/ready handshake to the frame-buffer writer.
- Adds runtime integer scaling, opaque/transparent mode and screen-edge clipping.

Parameters:
- GLYPH_W, 8, glyph width in pixels (bits per ROM row)
- GLYPH_H, 10, glyph height in rows
- CODE_W, 6, glyph code width
- COORD_W, 8, pixel coordinate width
- COLOUR_W, 6, colour width
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted only when busy=0
- code  in  CODE_W  glyph code
- org_x  in  COORD_W  top-left x of glyph
- org_y  in  COORD_W  top-left y of glyph
- fg  in  COLOUR_W  foreground colour
- bg  in  COLOUR_W  background colour, used only when opaque=1
- opaque  in  1  1: draw 0-bits in bg; 0: skip 0-bits
- scale  in  2  scale factor; 0 is treated as 1, otherwise 1..3
- rom_code  out  CODE_W  glyph code presented to ROM
- rom_row  out  log2(GLYPH_H)  row index presented to ROM
- rom_bits  in  GLYPH_W  combinational ROM row data; MSB is the leftmost pixel
- pix_valid  out  1  pixel write valid
- pix_ready  in  1  writer accepts pixel
- pix_x  out  COORD_W  pixel x
- pix_y  out  COORD_W  pixel y
- pix_colour  out  COLOUR_W  pixel colour
- busy  out  1  request in progress
- done  out  1  one-cycle pulse when the glyph is finished

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - state=IDLE
  - busy=0, done=0, pix_valid=0
  - pix_x=0, pix_y=0, pix_colour=0, rom_code=0, rom_row=0
  - all counters 0
- Reset mid-glyph aborts at the next edge: no done pulse, pix_valid drops.
- IDLE:
  - busy=0.
  - start=1 latches code, org_x, org_y, fg, bg, opaque and effective scale S.
  - Clears row, sy, col and sx; next state is FETCH.
- FETCH (1 cycle):
  - busy=1; rom_code=latched code; rom_row=row.
  - rom_bits are captured into the row register at the end of the cycle; next state is DRAW.
- DRAW: current bit b = rowreg[GLYPH_W-1-col].
  - px = org_x + col*S + sx
  - py = org_y + row*S + sy
  - Both sums are computed in COORD_W+2 bits with no wrap.
  - Visible when (b=1 or opaque=1) and px<SCREEN_W and py<SCREEN_H.
  - Visible pixel: pix_valid=1; pix_x/pix_y are px/py truncated to COORD_W; pix_colour = b ? fg : bg. The pixel advances only on pix_valid & pix_ready.
  - While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_colour hold stable.
  - Invisible pixel: pix_valid=0; advances in one cycle.
- Advance order, innermost first: sx (0..S-1), then col (0..GLYPH_W-1), then sy (0..S-1), then row.
  - At the end of sy, if row < GLYPH_H-1: row+1, go to FETCH.
  - Otherwise go to DONE.
  - Rows are not refetched across sy repeats.
- DONE: done=1 for exactly one cycle, busy=1; next state is IDLE. busy=0 from the following cycle.
- start while busy=1 is ignored and nothing is queued.
- start in the same cycle as the DONE to IDLE transition is ignored; it must be reissued when busy=0.
- Pixel throughput is 1 per cycle with pix_ready held high. The FETCH overhead is 1 cycle per row per glyph.
- Latency: start at edge N, FETCH in cycle N+1, first possible pix_valid in cycle N+2.
- Inputs other than rom_bits and pix_ready are don't-care while busy=1.

Test Plan:
- Bench ROM, code 5: row0=0x3C, other rows 0x00; org (10,20), scale=1, opaque=0, pix_ready=1.
  - Exactly 4 writes: (12,20), (13,20), (14,20), (15,20), all fg.
  - done pulses once; busy=0 afterwards.
- Same glyph, opaque=1, fg=0x3F, bg=0x01.
  - 80 writes covering x 10..17, y 20..29.
  - Only the four row0 pixels are 0x3F; all others are 0x01.
- Same glyph, scale=2, opaque=0, org (0,0).
  - 16 writes: x 4..11, y 0..1, in order sx, col, sy.
  - rom_row steps 0..9 once each.
- scale=0 behaves identically to scale=1, with a bit-identical write stream.
- org (156,115), opaque=1, scale=1.
  - Only x 156..159 and y 115..119 are emitted: 20 writes, none with x>=160 or y>=120.
  - done pulses once.
- pix_ready toggled randomly, then held low for 5 cycles on the 2nd write.
  - pix_x, pix_y and pix_colour stay stable while stalled; no pixel is dropped or duplicated.
  - A second start while busy is ignored.
  - reset asserted mid-glyph gives pix_valid=0 and busy=0 next cycle, with no done pulse.

Source files
------------

// File: rtl/glyph_blitter_if.sv
// rtl/glyph_blitter_if.sv - pixel write stream from the glyph blitter to the frame-buffer writer
interface glyph_blitter_if #(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6
);
  logic                pix_valid;
  logic                pix_ready;
  logic [COORD_W-1:0]  pix_x;
  logic [COORD_W-1:0]  pix_y;
  logic [COLOUR_W-1:0] pix_colour;

  modport master (output pix_valid, pix_x, pix_y, pix_colour, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_colour, output pix_ready);
endinterface

// File: rtl/glyph_blitter.sv
// rtl/glyph_blitter.sv - scaled, clipped glyph renderer walking an external glyph ROM
module glyph_blitter #(
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 10,
  parameter int CODE_W   = 6,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  localparam int ROW_W   = $clog2(GLYPH_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_W-1:0]   code,
  input  logic [COORD_W-1:0]  org_x,
  input  logic [COORD_W-1:0]  org_y,
  input  logic [COLOUR_W-1:0] fg,
  input  logic [COLOUR_W-1:0] bg,
  input  logic                opaque,
  input  logic [1:0]          scale,
  output logic [CODE_W-1:0]   rom_code,
  output logic [ROW_W-1:0]    rom_row,
  input  logic [GLYPH_W-1:0]  rom_bits,
  glyph_blitter_if.master     pix_if,
  output logic                busy,
  output logic                done
);
  localparam int COL_W = $clog2(GLYPH_W);
  localparam int PW    = COORD_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [COORD_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic                opaque_q, opaque_d;
  logic [1:0]          scale_q, scale_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [1:0]          sx_q, sx_d, sy_q, sy_d;
  logic [GLYPH_W-1:0]  bits_q, bits_d;

  logic          bit_cur, visible, step;
  logic [PW-1:0] px, py;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      opaque_q <= 1'b0;
      scale_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      bits_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      opaque_q <= opaque_d;
      scale_q  <= scale_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      bits_q   <= bits_d;
    end
  end

  // Sums are kept two bits wider than a coordinate so off-screen pixels clip instead of wrapping.
  assign bit_cur = bits_q[COL_W'(GLYPH_W-1) - col_q];
  assign px      = PW'(ox_q) + PW'(col_q) * PW'(scale_q) + PW'(sx_q);
  assign py      = PW'(oy_q) + PW'(row_q) * PW'(scale_q) + PW'(sy_q);
  assign visible = (bit_cur | opaque_q) && (px < PW'(SCREEN_W)) && (py < PW'(SCREEN_H));
  assign step    = !visible || pix_if.pix_ready;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    opaque_d = opaque_q;
    scale_d  = scale_q;
    row_d    = row_q;
    col_d    = col_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    bits_d   = bits_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d   = code;
          ox_d     = org_x;
          oy_d     = org_y;
          fg_d     = fg;
          bg_d     = bg;
          opaque_d = opaque;
          scale_d  = (scale == 2'd0) ? 2'd1 : scale;
          row_d    = '0;
          col_d    = '0;
          sx_d     = '0;
          sy_d     = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        bits_d  = rom_bits;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (step) begin
          if (sx_q != scale_q - 2'd1) begin
            sx_d = sx_q + 2'd1;
          end else begin
            sx_d = '0;
            if (col_q != COL_W'(GLYPH_W-1)) begin
              col_d = col_q + 1'b1;
            end else begin
              col_d = '0;
              if (sy_q != scale_q - 2'd1) begin
                sy_d = sy_q + 2'd1;
              end else begin
                sy_d = '0;
                if (row_q != ROW_W'(GLYPH_H-1)) begin
                  row_d   = row_q + 1'b1;
                  state_d = S_FETCH;
                end else begin
                  state_d = S_DONE;
                end
              end
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pix_if.pix_valid  = (state_q == S_DRAW) && visible;
  assign pix_if.pix_x      = pix_if.pix_valid ? px[COORD_W-1:0] : '0;
  assign pix_if.pix_y      = pix_if.pix_valid ? py[COORD_W-1:0] : '0;
  assign pix_if.pix_colour = pix_if.pix_valid ? (bit_cur ? fg_q : bg_q) : '0;
  assign rom_code          = code_q;
  assign rom_row           = row_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
endmodule
